// File: rtl/ara_pkg.sv
// Shared lane types for the VRF bank arbiter: addresses, data, byte strobes,
// operand-queue targets and the registered per-bank request.
package ara_pkg;

    localparam int unsigned VAddrWidth   = 10;
    localparam int unsigned ELEN         = 64;
    localparam int unsigned NrWritersDef = 4;

    typedef logic [VAddrWidth-1:0] vaddr_t;
    typedef logic [ELEN-1:0]       elen_t;
    typedef logic [ELEN/8-1:0]     strb_t;

    // Reader index doubles as the operand queue that receives the read data.
    typedef enum logic [3:0] {
        AluA, AluB, AluC, MulFPUA, MulFPUB, MulFPUC, MaskB, MaskM, StA, SlideAddrGenA
    } opqueue_e;

    localparam int unsigned NrOperandQueues = 10;

    typedef struct packed {
        vaddr_t   addr;
        logic     wen;
        elen_t    wdata;
        strb_t    be;
        opqueue_e tgt;
    } vrf_bank_req_t;

endpackage

// File: rtl/vrf_bank_rr_arb.sv
// Single-bank arbiter: writes beat reads unless reads have lost MaxStall cycles in a row;
// each class is served round-robin from its own pointer.
module vrf_bank_rr_arb
    import ara_pkg::*;
#(
    parameter int unsigned NrReaders = NrOperandQueues,
    parameter int unsigned NrWriters = NrWritersDef,
    parameter int unsigned MaxStall  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NrReaders-1:0] rd_cand_i,
    input  logic [NrWriters-1:0] wr_cand_i,
    output logic [NrReaders-1:0] rd_win_o,
    output logic [NrWriters-1:0] wr_win_o
);
    localparam int unsigned RdPtrW = (NrReaders > 1) ? $clog2(NrReaders) : 1;
    localparam int unsigned WrPtrW = (NrWriters > 1) ? $clog2(NrWriters) : 1;
    localparam int unsigned StallW = $clog2(MaxStall + 1);

    logic [RdPtrW-1:0]    rdPtr_d, rdPtr_q, rdNext;
    logic [WrPtrW-1:0]    wrPtr_d, wrPtr_q, wrNext;
    logic [StallW-1:0]    stall_d, stall_q;
    logic [NrReaders-1:0] rdPick;
    logic [NrWriters-1:0] wrPick;
    logic                 rdFound, wrFound, rdPrio, grantRd, grantWr;

    // Two passes: first from the pointer upwards, then wrap around from index 0.
    always_comb begin
        rdPick  = '0;
        rdFound = 1'b0;
        rdNext  = rdPtr_q;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NrReaders; i++) begin
                if (!rdFound && rd_cand_i[i] && ((pass == 1) || (i >= int'(rdPtr_q)))) begin
                    rdFound   = 1'b1;
                    rdPick[i] = 1'b1;
                    rdNext    = (i == NrReaders - 1) ? '0 : RdPtrW'(i + 1);
                end
            end
        end
    end

    always_comb begin
        wrPick  = '0;
        wrFound = 1'b0;
        wrNext  = wrPtr_q;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NrWriters; i++) begin
                if (!wrFound && wr_cand_i[i] && ((pass == 1) || (i >= int'(wrPtr_q)))) begin
                    wrFound   = 1'b1;
                    wrPick[i] = 1'b1;
                    wrNext    = (i == NrWriters - 1) ? '0 : WrPtrW'(i + 1);
                end
            end
        end
    end

    // Once reads have starved for MaxStall cycles they take the bank for one cycle.
    always_comb begin
        rdPrio   = (stall_q == StallW'(MaxStall));
        grantRd  = rdFound && (rdPrio || !wrFound);
        grantWr  = wrFound && !grantRd;
        rd_win_o = grantRd ? rdPick : '0;
        wr_win_o = grantWr ? wrPick : '0;
        rdPtr_d  = grantRd ? rdNext : rdPtr_q;
        wrPtr_d  = grantWr ? wrNext : wrPtr_q;
        stall_d  = '0;
        if (rdFound && !grantRd) begin
            stall_d = rdPrio ? stall_q : stall_q + StallW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            stall_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: rtl/vrf_bank_arbiter.sv
// Per-lane VRF bank scheduler: sorts read/write requesters onto single-port banks and
// registers one access per bank per cycle towards the VRF.
module vrf_bank_arbiter
    import ara_pkg::*;
#(
    parameter int unsigned NrBanks   = 8,
    parameter int unsigned NrReaders = NrOperandQueues,
    parameter int unsigned NrWriters = NrWritersDef,
    parameter int unsigned MaxStall  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NrReaders-1:0] rd_req_i,
    input  vaddr_t               rd_addr_i         [NrReaders],
    output logic [NrReaders-1:0] rd_gnt_o,
    input  logic [NrWriters-1:0] wr_req_i,
    input  vaddr_t               wr_addr_i         [NrWriters],
    input  elen_t                wr_data_i         [NrWriters],
    input  strb_t                wr_be_i           [NrWriters],
    output logic [NrWriters-1:0] wr_gnt_o,
    output logic [NrBanks-1:0]   vrf_req_o,
    output vaddr_t               vrf_addr_o        [NrBanks],
    output logic [NrBanks-1:0]   vrf_wen_o,
    output elen_t                vrf_wdata_o       [NrBanks],
    output strb_t                vrf_be_o          [NrBanks],
    output opqueue_e             vrf_tgt_opqueue_o [NrBanks]
);
    localparam int unsigned BankW = $clog2(NrBanks);
    localparam int unsigned TgtW  = $bits(opqueue_e);

    logic [NrReaders-1:0] rdWin [NrBanks];
    logic [NrWriters-1:0] wrWin [NrBanks];

    for (genvar b = 0; b < NrBanks; b++) begin : gen_bank
        logic [NrReaders-1:0] rdCand;
        logic [NrWriters-1:0] wrCand;
        vrf_bank_req_t        bankReq_d, bankReq_q;
        logic                 valid_d, valid_q;

        for (genvar r = 0; r < NrReaders; r++) begin : gen_rd_cand
            assign rdCand[r] = rd_req_i[r] && (rd_addr_i[r][BankW-1:0] == BankW'(b));
        end
        for (genvar w = 0; w < NrWriters; w++) begin : gen_wr_cand
            assign wrCand[w] = wr_req_i[w] && (wr_addr_i[w][BankW-1:0] == BankW'(b));
        end

        vrf_bank_rr_arb #(
            .NrReaders(NrReaders),
            .NrWriters(NrWriters),
            .MaxStall (MaxStall)
        ) i_arb (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .rd_cand_i(rdCand),
            .wr_cand_i(wrCand),
            .rd_win_o (rdWin[b]),
            .wr_win_o (wrWin[b])
        );

        // Winners are one-hot, so OR-ing the selected fields acts as a mux; idle banks send zeros.
        always_comb begin
            bankReq_d = '0;
            valid_d   = (|rdWin[b]) || (|wrWin[b]);
            for (int r = 0; r < NrReaders; r++) begin
                if (rdWin[b][r]) begin
                    bankReq_d.addr = rd_addr_i[r] >> BankW;
                    bankReq_d.tgt  = opqueue_e'(TgtW'(r));
                end
            end
            for (int w = 0; w < NrWriters; w++) begin
                if (wrWin[b][w]) begin
                    bankReq_d.addr  = wr_addr_i[w] >> BankW;
                    bankReq_d.wen   = 1'b1;
                    bankReq_d.wdata = wr_data_i[w];
                    bankReq_d.be    = wr_be_i[w];
                end
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                valid_q   <= 1'b0;
                bankReq_q <= '0;
            end else begin
                valid_q   <= valid_d;
                bankReq_q <= bankReq_d;
            end
        end

        assign vrf_req_o[b]         = valid_q;
        assign vrf_addr_o[b]        = bankReq_q.addr;
        assign vrf_wen_o[b]         = bankReq_q.wen;
        assign vrf_wdata_o[b]       = bankReq_q.wdata;
        assign vrf_be_o[b]          = bankReq_q.be;
        assign vrf_tgt_opqueue_o[b] = bankReq_q.tgt;
    end

    // A requester maps to exactly one bank, so OR-ing the bank winners never double-grants.
    always_comb begin
        rd_gnt_o = '0;
        wr_gnt_o = '0;
        if (!rst_i) begin
            for (int b = 0; b < NrBanks; b++) begin
                rd_gnt_o = rd_gnt_o | rdWin[b];
                wr_gnt_o = wr_gnt_o | wrWin[b];
            end
        end
    end

    for (genvar r = 0; r < NrReaders; r++) begin : gen_rd_hold
        assert property (@(posedge clk_i) disable iff (rst_i)
            (rd_req_i[r] && !rd_gnt_o[r]) |=> (rd_req_i[r] && $stable(rd_addr_i[r])))
            else $error("read request %0d dropped or re-addressed before grant", r);
    end
    for (genvar w = 0; w < NrWriters; w++) begin : gen_wr_hold
        assert property (@(posedge clk_i) disable iff (rst_i)
            (wr_req_i[w] && !wr_gnt_o[w]) |=> (wr_req_i[w] && $stable(wr_addr_i[w])))
            else $error("write request %0d dropped or re-addressed before grant", w);
    end

endmodule

// File: tb/tb_vrf_bank_arbiter.sv
// Scoreboard bench for vrf_bank_arbiter: directed cycles push hand-computed expectations,
// a negedge monitor pops one whenever grants or bank requests are active.
module tb_vrf_bank_arbiter;
    import ara_pkg::*;

    localparam int NB = 8;
    localparam int NR = NrOperandQueues;
    localparam int NW = 4;

    localparam elen_t W0 = 64'hDEAD_BEEF_0000_0000;
    localparam elen_t W1 = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam elen_t W2 = 64'h0123_4567_89AB_CDEF;
    localparam elen_t W3 = 64'h5555_AAAA_5555_AAAA;
    localparam strb_t B0 = 8'h0F;
    localparam strb_t B1 = 8'hF0;
    localparam strb_t B2 = 8'hFF;
    localparam strb_t B3 = 8'h3C;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NR-1:0] rdReq;
    vaddr_t        rdAddr   [NR];
    logic [NR-1:0] rdGnt;
    logic [NW-1:0] wrReq;
    vaddr_t        wrAddr   [NW];
    elen_t         wrData   [NW];
    strb_t         wrBe     [NW];
    logic [NW-1:0] wrGnt;
    logic [NB-1:0] vrfReq, vrfWen;
    vaddr_t        vrfAddr  [NB];
    elen_t         vrfWdata [NB];
    strb_t         vrfBe    [NB];
    opqueue_e      vrfTgt   [NB];

    typedef struct {
        logic [NR-1:0] rdGnt;
        logic [NW-1:0] wrGnt;
        logic [NB-1:0] vrfReq;
        logic [NB-1:0] vrfWen;
        int            chkBank;
        vaddr_t        addr;
        elen_t         wdata;
        strb_t         be;
        int            tgt;
    } exp_t;

    exp_t expQ[$];
    int   testsRun    = 0;
    int   testsFailed = 0;

    always #5 clk = ~clk;

    vrf_bank_arbiter dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .rd_req_i         (rdReq),
        .rd_addr_i        (rdAddr),
        .rd_gnt_o         (rdGnt),
        .wr_req_i         (wrReq),
        .wr_addr_i        (wrAddr),
        .wr_data_i        (wrData),
        .wr_be_i          (wrBe),
        .wr_gnt_o         (wrGnt),
        .vrf_req_o        (vrfReq),
        .vrf_addr_o       (vrfAddr),
        .vrf_wen_o        (vrfWen),
        .vrf_wdata_o      (vrfWdata),
        .vrf_be_o         (vrfBe),
        .vrf_tgt_opqueue_o(vrfTgt)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive requests just after the edge and queue what that cycle must show.
    task automatic applyStimulus(input logic [NR-1:0] rq, input logic [NW-1:0] wq,
                                 input logic [NR-1:0] eRd, input logic [NW-1:0] eWr,
                                 input logic [NB-1:0] eReq, input logic [NB-1:0] eWen,
                                 input int chkBank = -1, input vaddr_t eAddr = '0,
                                 input elen_t eWdata = '0, input strb_t eBe = '0,
                                 input int eTgt = 0, input bit relRst = 1'b0);
        exp_t e;
        @(posedge clk);
        #1;
        if (relRst) rst = 1'b0;
        rdReq = rq;
        wrReq = wq;
        e.rdGnt   = eRd;
        e.wrGnt   = eWr;
        e.vrfReq  = eReq;
        e.vrfWen  = eWen;
        e.chkBank = chkBank;
        e.addr    = eAddr;
        e.wdata   = eWdata;
        e.be      = eBe;
        e.tgt     = eTgt;
        if ((eRd != '0) || (eWr != '0) || (eReq != '0)) expQ.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && ((rdGnt != '0) || (wrGnt != '0) || (vrfReq != '0))) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected activity: rd_gnt=0x%0h wr_gnt=0x%0h vrf_req=0x%0h, expected none",
                             rdGnt, wrGnt, vrfReq);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rd_gnt", 64'(rdGnt), 64'(e.rdGnt));
                    checkOutput("wr_gnt", 64'(wrGnt), 64'(e.wrGnt));
                    checkOutput("vrf_req", 64'(vrfReq), 64'(e.vrfReq));
                    checkOutput("vrf_wen", 64'(vrfWen), 64'(e.vrfWen));
                    if (e.chkBank >= 0) begin
                        checkOutput("vrf_addr", 64'(vrfAddr[e.chkBank]), 64'(e.addr));
                        checkOutput("vrf_wdata", vrfWdata[e.chkBank], e.wdata);
                        checkOutput("vrf_be", 64'(vrfBe[e.chkBank]), 64'(e.be));
                        checkOutput("vrf_tgt", 64'(vrfTgt[e.chkBank]), 64'(e.tgt));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        rdReq = '0;
        wrReq = '0;
        for (int i = 0; i < NR; i++) rdAddr[i] = '0;
        for (int i = 0; i < NW; i++) wrAddr[i] = '0;
        wrData[0] = W0; wrData[1] = W1; wrData[2] = W2; wrData[3] = W3;
        wrBe[0]   = B0; wrBe[1]   = B1; wrBe[2]   = B2; wrBe[3]   = B3;

        #1 rst = 1'b1;
        #11;
        checkOutput("reset vrf_req", 64'(vrfReq), 64'h0);
        checkOutput("reset vrf_wen", 64'(vrfWen), 64'h0);
        checkOutput("reset vrf_addr", 64'(vrfAddr[0]), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Single read, bank 3, then one-cycle-late bank request.
        rdAddr[2] = 10'h013;
        applyStimulus(10'h004, 4'h0, 10'h004, 4'h0, 8'h00, 8'h00);
        applyStimulus(10'h000, 4'h0, 10'h000, 4'h0, 8'h08, 8'h00, 3, 10'h002, '0, '0, 2);
        applyStimulus(10'h000, 4'h0, 10'h000, 4'h0, 8'h00, 8'h00);

        // Reader 5 vs writer 1 on bank 4: four write wins, forced read win, then write.
        rdAddr[5] = 10'h00C;
        wrAddr[1] = 10'h024;
        applyStimulus(10'h020, 4'h2, 10'h000, 4'h2, 8'h00, 8'h00);
        applyStimulus(10'h020, 4'h2, 10'h000, 4'h2, 8'h10, 8'h10, 4, 10'h004, W1, B1, 0);
        applyStimulus(10'h020, 4'h2, 10'h000, 4'h2, 8'h10, 8'h10);
        applyStimulus(10'h020, 4'h2, 10'h000, 4'h2, 8'h10, 8'h10);
        applyStimulus(10'h020, 4'h2, 10'h020, 4'h0, 8'h10, 8'h10);
        applyStimulus(10'h020, 4'h2, 10'h000, 4'h2, 8'h10, 8'h00, 4, 10'h001, '0, '0, 5);
        applyStimulus(10'h020, 4'h0, 10'h020, 4'h0, 8'h10, 8'h10);
        applyStimulus(10'h000, 4'h0, 10'h000, 4'h0, 8'h10, 8'h00);
        applyStimulus(10'h000, 4'h0, 10'h000, 4'h0, 8'h00, 8'h00);

        // Three writers on bank 0 rotate 0,1,2,0,1,2 then drain.
        wrAddr[0] = 10'h000;
        wrAddr[1] = 10'h008;
        wrAddr[2] = 10'h010;
        applyStimulus(10'h000, 4'h7, 10'h000, 4'h1, 8'h00, 8'h00);
        for (int k = 1; k <= 5; k++) begin
            if (k == 3)
                applyStimulus(10'h000, 4'h7, 10'h000, NW'(1 << (k % 3)), 8'h01, 8'h01,
                              0, 10'h002, W2, B2, 0);
            else
                applyStimulus(10'h000, 4'h7, 10'h000, NW'(1 << (k % 3)), 8'h01, 8'h01);
        end
        applyStimulus(10'h000, 4'h3, 10'h000, 4'h1, 8'h01, 8'h01);
        applyStimulus(10'h000, 4'h2, 10'h000, 4'h2, 8'h01, 8'h01);
        applyStimulus(10'h000, 4'h0, 10'h000, 4'h0, 8'h01, 8'h01);
        applyStimulus(10'h000, 4'h0, 10'h000, 4'h0, 8'h00, 8'h00);

        // Eight readers, eight banks, all granted together.
        for (int i = 0; i < 8; i++) rdAddr[i] = vaddr_t'(8 * (i + 1) + i);
        applyStimulus(10'h0FF, 4'h0, 10'h0FF, 4'h0, 8'h00, 8'h00);
        applyStimulus(10'h000, 4'h0, 10'h000, 4'h0, 8'hFF, 8'h00, 7, 10'h008, '0, '0, 7);

        // Async reset while vrf_req is 0xFF; pointers moved earlier must restart at 0.
        #6;
        rdAddr[8] = 10'h00B;
        wrAddr[3] = 10'h018;
        rdReq = 10'h108;
        wrReq = 4'hA;
        rst   = 1'b1;
        #1;
        checkOutput("async reset vrf_req", 64'(vrfReq), 64'h0);
        checkOutput("async reset vrf_addr", 64'(vrfAddr[7]), 64'h0);
        checkOutput("reset rd_gnt", 64'(rdGnt), 64'h0);
        checkOutput("reset wr_gnt", 64'(wrGnt), 64'h0);
        applyStimulus(10'h108, 4'hA, 10'h008, 4'h2, 8'h00, 8'h00, -1, '0, '0, '0, 0, 1'b1);
        applyStimulus(10'h100, 4'h8, 10'h100, 4'h8, 8'h09, 8'h01, 3, 10'h004, '0, '0, 3);
        applyStimulus(10'h000, 4'h0, 10'h000, 4'h0, 8'h09, 8'h01, 0, 10'h003, W3, B3, 0);
        applyStimulus(10'h000, 4'h0, 10'h000, 4'h0, 8'h00, 8'h00);

        // Read to bank 1 and write to bank 2 coexist.
        rdAddr[4] = 10'h009;
        wrAddr[0] = 10'h00A;
        applyStimulus(10'h010, 4'h1, 10'h010, 4'h1, 8'h00, 8'h00);
        applyStimulus(10'h000, 4'h0, 10'h000, 4'h0, 8'h06, 8'h04, 2, 10'h001, W0, B0, 0);
        applyStimulus(10'h000, 4'h0, 10'h000, 4'h0, 8'h00, 8'h00);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", 64'(expQ.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
